fb_scanout_arbiter: RTL and testbench

//  Shares one single-port framebuffer RAM (FB_W x FB_H palette indices) between the PPU pixel writer and VGA scanout.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_line_buffer.sv | 33 +++
 rtl/fb_scanout_arbiter.sv | 177 +++++++++++++++++
 tb/tb_fb_scanout_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg : shared types and default geometry for the framebuffer scanout path
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [9:0] Y_INVALID = 10'h3FF;

  localparam int FB_W_DEF  = 256;
  localparam int FB_H_DEF  = 240;
  localparam int DW_DEF    = 6;
  localparam int AW_DEF    = 16;
  localparam int X_OFF_DEF = 64;

endpackage

`default_nettype wire

// File: rtl/fb_line_buffer.sv
// ---------------------------------------------------------------------------
// fb_line_buffer : two-bank line buffer, one write port (fetch), one read port (scanout)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fb_line_buffer #(
  parameter int FB_W = 256,
  parameter int DW   = 6,
  parameter int CW   = $clog2(FB_W)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [CW-1:0] wr_col,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_bank,
  input  logic [CW-1:0] rd_col,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:2*FB_W-1];

  always_ff @(posedge clock) begin
    if (wr_en) mem[{wr_bank, wr_col}] <= wr_data;
  end

  // Asynchronous read; the top registers the pixel.
  assign rd_data = mem[{rd_bank, rd_col}];

endmodule

`default_nettype wire

// File: rtl/fb_scanout_arbiter.sv
// ---------------------------------------------------------------------------
// fb_scanout_arbiter : shares framebuffer SRAM between PPU writes and 2x-scaled VGA
// line prefetch. Optional FB_UNDERRUN_CNT_EN adds a saturating underrun counter.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fb_scanout_arbiter
  import fb_pkg::*;
#(
  parameter int FB_W  = FB_W_DEF,
  parameter int FB_H  = FB_H_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int X_OFF = X_OFF_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pix_en,
  input  logic [9:0]    x_addr,
  input  logic [9:0]    y_addr,
  output logic [DW-1:0] pix_out,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          underrun
`ifdef FB_UNDERRUN_CNT_EN
  ,
  output logic [7:0]    underrun_cnt
`endif
);

  localparam int CW = $clog2(FB_W);
  localparam int LW = AW - CW;
  localparam logic [9:0]  FB_H_V     = 10'(FB_H);
  localparam logic [CW:0] FETCH_LAST = (CW+1)'(FB_W);
  localparam logic [10:0] X_LO       = 11'(X_OFF);
  localparam logic [10:0] X_HI       = 11'(X_OFF + 2*FB_W);

  state_t        state, state_next;
  logic [9:0]    y_prev;
  logic          front, pending, armed, fetch_bank;
  logic [LW-1:0] next_line, fetch_line;
  logic [CW:0]   col;

  logic          y_event, frame_end, swap, line_ok, fetch_start, underrun_evt;
  logic [9:0]    y_half_next;

  logic          lb_we;
  logic [CW-1:0] lb_col, rd_col;
  logic [DW-1:0] rd_data;
  logic [10:0]   x_ext;
  logic          in_img;

  assign y_event      = pix_en && (y_addr != y_prev);
  assign frame_end    = y_event && (y_addr == Y_INVALID);
  assign swap         = y_event && (y_addr != Y_INVALID) && !y_addr[0];
  assign y_half_next  = {1'b0, y_addr[9:1]} + 10'd1;
  assign line_ok      = y_half_next < FB_H_V;
  assign fetch_start  = (state == IDLE) && pending;
  assign underrun_evt = swap && armed && (pending || state == FETCH);

  always_ff @(posedge clock) begin
    if (reset) begin
      y_prev     <= Y_INVALID;
      front      <= 1'b0;
      pending    <= 1'b0;
      armed      <= 1'b0;
      next_line  <= '0;
      fetch_line <= '0;
      fetch_bank <= 1'b1;
      col        <= '0;
      underrun   <= 1'b0;
    end else begin
      if (pix_en) y_prev <= y_addr;
      if (swap) front <= ~front;
      // A swap in the same cycle flips the bank first, so the fetch lands in the new back bank.
      if (fetch_start) begin
        pending    <= 1'b0;
        fetch_line <= next_line;
        fetch_bank <= swap ? front : ~front;
      end
      if (frame_end) begin
        next_line <= '0;
        pending   <= 1'b1;
        armed     <= 1'b1;
      end else if (swap && line_ok) begin
        next_line <= LW'(y_half_next);
        pending   <= 1'b1;
      end
      if (fetch_start)          col <= '0;
      else if (state == FETCH)  col <= col + (CW+1)'(1);
      if (underrun_evt) underrun <= 1'b1;
    end
  end

`ifdef FB_UNDERRUN_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)                                      underrun_cnt <= 8'd0;
    else if (underrun_evt && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pending)     state_next = FETCH;
        else if (wr_req) state_next = WRITE;
      end
      FETCH:   if (col == FETCH_LAST) state_next = IDLE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data for column c returns while column c+1 is addressed, hence the col-1 capture.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    lb_we     = 1'b0;
    case (state)
      FETCH: begin
        if (!col[CW]) mem_addr = {fetch_line, col[CW-1:0]};
        lb_we = (col != '0);
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        wr_ack    = 1'b1;
      end
      default: ;
    endcase
  end

  assign lb_col = col[CW-1:0] - CW'(1);

  fb_line_buffer #(
    .FB_W (FB_W),
    .DW   (DW),
    .CW   (CW)
  ) u_line_buffer (
    .clock   (clock),
    .wr_en   (lb_we),
    .wr_bank (fetch_bank),
    .wr_col  (lb_col),
    .wr_data (mem_rdata),
    .rd_bank (front),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  assign x_ext  = {1'b0, x_addr};
  assign in_img = (y_addr != Y_INVALID) && (x_ext >= X_LO) && (x_ext < X_HI);
  assign rd_col = CW'((x_ext - X_LO) >> 1);

  always_ff @(posedge clock) begin
    if (reset) pix_out <= '0;
    else       pix_out <= in_img ? rd_data : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_fb_scanout_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_scanout_arbiter : self-checking bench with an SRAM model and expectation queues
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fb_scanout_arbiter;

  localparam int DW = 6;
  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pix_en = 1'b1;
  logic [9:0]    x_addr = 10'h3FF;
  logic [9:0]    y_addr = 10'd479;
  logic [DW-1:0] pix_out;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          underrun;
`ifdef FB_UNDERRUN_CNT_EN
  logic [7:0]    underrun_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] pix_q[$];
  logic [AW-1:0] addr_q[$];
  logic [AW+DW-1:0] wr_q[$];

  logic [DW-1:0] sram [0:65535];

  fb_scanout_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .pix_en    (pix_en),
    .x_addr    (x_addr),
    .y_addr    (y_addr),
    .pix_out   (pix_out),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .underrun  (underrun)
`ifdef FB_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic apply_reset(input logic [9:0] y);
    @(negedge clock);
    reset  = 1'b1;
    y_addr = y;
    wait_cycles(4);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(10'd479);
    checks++; if (pix_out !== '0)  begin failures++; $display("FAIL reset_pix_out got %0h want 0", pix_out); end
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL reset_wr_ack got %0b want 0", wr_ack); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got %0b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
    checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_wdata got %0h want 0", mem_wdata); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got %0b want 0", underrun); end
`ifdef FB_UNDERRUN_CNT_EN
    checks++; if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL reset_underrun_cnt got %0d want 0", underrun_cnt); end
`endif
  endtask

  task automatic test_fetch_scan();
    logic [9:0]    xs [6] = '{10'd64, 10'd65, 10'd66, 10'd575, 10'd576, 10'h3FF};
    logic [DW-1:0] ex [6] = '{6'd0, 6'd0, 6'd1, 6'h3F, 6'd0, 6'd0};
    logic [DW-1:0] exp_px;
    logic [AW-1:0] exp_a;
    bit found = 0;
    @(negedge clock);
    y_addr = 10'h3FF;
    for (int c = 2; c < 256; c++) addr_q.push_back(AW'(c));
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (mem_addr == AW'(1)) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL fetch_start got no address 1 want fetch of line 0"); end
    while (addr_q.size() > 0) begin
      @(negedge clock);
      exp_a = addr_q.pop_front();
      checks++;
      if (mem_addr !== exp_a) begin failures++; $display("FAIL fetch_addr got %0h want %0h", mem_addr, exp_a); end
    end
    wait_cycles(5);
    y_addr = 10'd0;
    wait_cycles(2);
    for (int i = 0; i < 6; i++) begin
      x_addr = xs[i];
      pix_q.push_back(ex[i]);
      @(negedge clock);
      exp_px = pix_q.pop_front();
      checks++;
      if (pix_out !== exp_px) begin failures++; $display("FAIL scan_x%0d got %0h want %0h", xs[i], pix_out, exp_px); end
    end
  endtask

  task automatic test_write_during_fetch();
    int last_fetch = -1;
    int ack_idx = -1;
    int we_count = 0;
    logic [AW+DW-1:0] exp_w;
    logic [9:0]    xs [3] = '{10'd168, 10'd169, 10'd170};
    logic [DW-1:0] ex [3] = '{6'h2A, 6'h2A, 6'h35};
    logic [DW-1:0] exp_px;
    wait_cycles(300);
    y_addr = 10'd2;
    wait_cycles(3);
    wr_req  = 1'b1;
    wr_addr = 16'h1234;
    wr_data = 6'h2A;
    wr_q.push_back({16'h1234, 6'h2A});
    for (int i = 1; i < 300; i++) begin
      @(negedge clock);
      if (mem_addr == 16'h02FF && !mem_we) last_fetch = i;
      if (mem_we) we_count++;
      if (wr_ack && ack_idx < 0) begin
        ack_idx = i;
        exp_w = wr_q.pop_front();
        checks++;
        if ({mem_addr, mem_wdata} !== exp_w || mem_we !== 1'b1) begin
          failures++; $display("FAIL write_port got we=%0b addr=%0h data=%0h want addr=%0h data=%0h",
                               mem_we, mem_addr, mem_wdata, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        end
        wr_req = 1'b0;
      end
    end
    checks++; if (ack_idx < 0) begin failures++; $display("FAIL write_ack got none want one"); end
    checks++; if (ack_idx <= last_fetch) begin failures++; $display("FAIL ack_after_fetch got ack=%0d want after %0d", ack_idx, last_fetch); end
    checks++; if (ack_idx > 258) begin failures++; $display("FAIL ack_latency got %0d want <= 258", ack_idx); end
    checks++; if (we_count != 1) begin failures++; $display("FAIL we_pulses got %0d want 1", we_count); end
    y_addr = 10'd34;
    wait_cycles(300);
    y_addr = 10'd36;
    wait_cycles(2);
    for (int i = 0; i < 3; i++) begin
      x_addr = xs[i];
      pix_q.push_back(ex[i]);
      @(negedge clock);
      exp_px = pix_q.pop_front();
      checks++;
      if (pix_out !== exp_px) begin failures++; $display("FAIL readback_x%0d got %0h want %0h", xs[i], pix_out, exp_px); end
    end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL no_underrun got %0b want 0", underrun); end
  endtask

  task automatic test_underrun();
    y_addr = 10'h3FF;
    wait_cycles(2);
    y_addr = 10'd0;
    wait_cycles(1);
    y_addr = 10'd2;
    wait_cycles(2);
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_set got %0b want 1", underrun); end
    wait_cycles(600);
    y_addr = 10'h3FF;
    wait_cycles(300);
    y_addr = 10'd0;
    wait_cycles(300);
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_sticky got %0b want 1", underrun); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset(10'd100);
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL midreset_clear got %0b want 0", underrun); end
    wait_cycles(3);
    y_addr = 10'd102;
    wait_cycles(2);
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL unarmed_swap got %0b want 0", underrun); end
    y_addr = 10'h3FF;
    wait_cycles(2);
    y_addr = 10'd0;
    wait_cycles(2);
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL armed_swap got %0b want 1", underrun); end
  endtask

`ifdef FB_UNDERRUN_CNT_EN
  task automatic test_underrun_cnt();
    apply_reset(10'd479);
    wait_cycles(1);
    y_addr = 10'h3FF;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (i == 10) begin
        checks++;
        if (underrun_cnt !== 8'd10) begin failures++; $display("FAIL cnt_10 got %0d want 10", underrun_cnt); end
      end
      y_addr = 10'((2 * i) % 480);
    end
    wait_cycles(2);
    checks++; if (underrun_cnt !== 8'd255) begin failures++; $display("FAIL cnt_sat got %0d want 255", underrun_cnt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = DW'(i);
    test_reset();
    test_fetch_scan();
    test_write_during_fetch();
    test_underrun();
    test_reset_mid_frame();
`ifdef FB_UNDERRUN_CNT_EN
    test_underrun_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
